// File: rtl/profiler_pkg.sv
// profiler_pkg: shared widths, reset constants and FSM encoding for the
// cycle profiler slice (cycle_profiler, profiler_stats).
package profiler_pkg;
  localparam int          CYC_W    = 32;
  localparam int          SUM_W    = 48;
  localparam logic [31:0] MIN_INIT = 32'hFFFF_FFFF;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} prof_state_t;
endpackage

// File: rtl/profiler_stats.sv
// profiler_stats: interval statistics. On each record strobe, captures the
// elapsed value into last/min/max, bumps a saturating sample counter and,
// when PROFILER_ACCUM_EN is defined, a 48-bit wrapping accumulator.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   clear              sync clear of all statistics
//   rec                record strobe (one interval closed this cycle)
//   elapsed            interval length to record
//   result_valid       registered copy of rec (one-cycle pulse)
//   last/min/max_elapsed, sample_cnt, cnt_sat, sum_elapsed  statistics
import profiler_pkg::*;

module profiler_stats #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             rec,
  input  logic [CYC_W-1:0] elapsed,
  output logic             result_valid,
  output logic [CYC_W-1:0] last_elapsed,
  output logic [CYC_W-1:0] min_elapsed,
  output logic [CYC_W-1:0] max_elapsed,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             cnt_sat,
  output logic [SUM_W-1:0] sum_elapsed
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             r_vld;
  logic [CYC_W-1:0] r_last, r_min, r_max;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= 1'b0;
      r_last <= '0;
      r_min  <= MIN_INIT;
      r_max  <= '0;
      r_cnt  <= '0;
      r_sat  <= 1'b0;
    end else if (clear) begin
      r_vld  <= 1'b0;
      r_last <= '0;
      r_min  <= MIN_INIT;
      r_max  <= '0;
      r_cnt  <= '0;
      r_sat  <= 1'b0;
    end else begin
      r_vld <= rec;
      if (rec) begin
        r_last <= elapsed;
        // strict compares: ties keep the existing extreme
        if (elapsed < r_min) r_min <= elapsed;
        if (elapsed > r_max) r_max <= elapsed;
        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
        // sticky flag set on the edge the counter lands on all-ones
        if (r_cnt >= CNT_MAX - 1'b1) r_sat <= 1'b1;
      end
    end
  end

`ifdef PROFILER_ACCUM_EN
  logic [SUM_W-1:0] r_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_sum <= '0;
    else if (clear)   r_sum <= '0;
    else if (rec)     r_sum <= r_sum + {{(SUM_W-CYC_W){1'b0}}, elapsed};
  end

  assign sum_elapsed = r_sum;
`else
  assign sum_elapsed = '0;
`endif

  assign result_valid = r_vld;
  assign last_elapsed = r_last;
  assign min_elapsed  = r_min;
  assign max_elapsed  = r_max;
  assign sample_cnt   = r_cnt;
  assign cnt_sat      = r_sat;
endmodule

// File: rtl/cycle_profiler.sv
// cycle_profiler: measures cycles between start/stop markers using the
// free-running cycle count on hc_in. Keeps last/min/max interval, a
// saturating sample count and (macro PROFILER_ACCUM_EN) a running sum.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   hc_in          current cycle count
//   start, stop    interval markers (single-cycle pulses)
//   clear          sync clear of statistics and FSM (beats start/stop)
//   busy           interval open
//   result_valid   one-cycle pulse after an interval is recorded
//   last/min/max_elapsed, sample_cnt, cnt_sat, sum_elapsed  statistics
import profiler_pkg::*;

module cycle_profiler #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CYC_W-1:0] hc_in,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  output logic             busy,
  output logic             result_valid,
  output logic [CYC_W-1:0] last_elapsed,
  output logic [CYC_W-1:0] min_elapsed,
  output logic [CYC_W-1:0] max_elapsed,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             cnt_sat,
  output logic [SUM_W-1:0] sum_elapsed
);
  prof_state_t      r_state, w_next;
  logic [CYC_W-1:0] r_t_start;
  logic [CYC_W-1:0] w_elapsed;
  logic             w_record;

  // unsigned subtraction absorbs a single counter wrap
  assign w_elapsed = hc_in - r_t_start;
  assign w_record  = !clear && (r_state == RUN) && stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (clear) w_next = IDLE;
    else begin
      case (r_state)
        IDLE:    if (start) w_next = RUN;
        // start together with stop reopens immediately (back-to-back)
        RUN:     if (stop && !start) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (r_state == RUN);
  end

  // any accepted start (IDLE open, RUN restart, back-to-back) retimes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_t_start <= '0;
    else if (clear)  r_t_start <= '0;
    else if (start)  r_t_start <= hc_in;
  end

  profiler_stats #(.CNT_W(CNT_W)) u_stats (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .rec          (w_record),
    .elapsed      (w_elapsed),
    .result_valid (result_valid),
    .last_elapsed (last_elapsed),
    .min_elapsed  (min_elapsed),
    .max_elapsed  (max_elapsed),
    .sample_cnt   (sample_cnt),
    .cnt_sat      (cnt_sat),
    .sum_elapsed  (sum_elapsed)
  );
endmodule
